// File: rtl/usb_encoder_pkg.sv
// Frame constants, state encodings and the CRC8-ATM byte step. The frame decoder
// uses the same definitions.
package usb_encoder_pkg;

   localparam logic [7:0] FRM_SYNC0   = 8'h5E;
   localparam logic [7:0] FRM_SYNC1   = 8'h4D;
   localparam int         FRM_MAX_LEN = 120;
   localparam int         HDR_LEN     = 6;

   localparam logic [2:0] OFS_ADDR = 3'd2;
   localparam logic [2:0] OFS_NH   = 3'd3;
   localparam logic [2:0] OFS_NL   = 3'd4;
   localparam logic [2:0] OFS_HCRC = 3'd5;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_HDR  = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_CRC  = 3'd4;

   // Poly 0x07, MSB first, no reflection, no output xor.
   function automatic logic [7:0] crc8_atm_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/usb_encoder_if.sv
// System-side payload strobe plus USB FIFO side write strobe of the frame encoder.
interface usb_encoder_if;
   logic [7:0] d;
   logic       d_accepted;
   logic [7:0] addr;
   logic       tx_ready;
   logic [7:0] q;
   logic       q_accepted;
   logic       busy;
   logic       frame_done;

   modport master (output d, d_accepted, addr, tx_ready,
                   input  q, q_accepted, busy, frame_done);
   modport slave  (input  d, d_accepted, addr, tx_ready,
                   output q, q_accepted, busy, frame_done);
endinterface

// File: rtl/crc8_atm_calc.sv
// Running CRC8-ATM. crc_o is the value including this cycle's byte, so a CRC
// byte can be emitted on the same edge its last input byte is absorbed.
module crc8_atm_calc
   import usb_encoder_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);
   logic [7:0] crc_q;
   logic [7:0] crc_upd;

   assign crc_upd = en_i ? crc8_atm_byte(crc_q, data_i) : crc_q;
   assign crc_o   = crc_upd;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)     crc_q <= 8'h00;
      else if (clr_i) crc_q <= 8'h00;
      else            crc_q <= crc_upd;
   end
endmodule

// File: rtl/ram_128B.sv
// 128-byte payload buffer: one write port, one registered read port.
module ram_128B (
   input  logic       clk,
   input  logic       we_i,
   input  logic [6:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [6:0] raddr_i,
   output logic [7:0] rdata_o
);
   logic [7:0] mem_q [0:127];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/usb_encoder.sv
// Buffers one payload burst, then emits SYNC0 SYNC1 ADDR NH NL HCRC DATA[N] FCRC
// toward the USB FIFO, one byte per cycle that tx_ready allows.
//
//   state | meaning
//   IDLE  | waiting for the first payload byte
//   LOAD  | storing payload bytes, saturating at MAX_LEN
//   HDR   | emitting the six header bytes
//   DATA  | emitting buffer[0..len-1]
//   CRC   | emitting FCRC, pulsing frame_done
module usb_encoder
   import usb_encoder_pkg::*;
#(
   parameter int         MAX_LEN = FRM_MAX_LEN,
   parameter logic [7:0] SYNC0   = FRM_SYNC0,
   parameter logic [7:0] SYNC1   = FRM_SYNC1
) (
   input  logic          clk,
   input  logic          n_rst,
   usb_encoder_if.slave  bus
);
   logic [2:0] state_q, state_d;
   logic [6:0] len_q, len_d;
   logic [7:0] addr_q, addr_d;
   logic [2:0] hdr_idx_q, hdr_idx_d;
   logic [6:0] rd_ptr_q, rd_ptr_d;
   logic [7:0] q_q, q_d;
   logic       q_acc_q, q_acc_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic       ram_we;
   logic [6:0] ram_waddr;
   logic [7:0] ram_rdata;
   logic [7:0] crc_cur;
   logic [7:0] hdr_byte;

   // Read address follows the next pointer, so ram_rdata always holds
   // buffer[rd_ptr_q] and a stalled tx_ready never loses the in-flight read.
   ram_128B u_buf (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (bus.d),
      .raddr_i (rd_ptr_d),
      .rdata_o (ram_rdata)
   );

   crc8_atm_calc u_crc (
      .clk    (clk),
      .n_rst  (n_rst),
      .clr_i  (state_q == ST_IDLE),
      .en_i   (q_acc_q),
      .data_i (q_q),
      .crc_o  (crc_cur)
   );

   always_comb begin
      hdr_byte = SYNC0;
      case (hdr_idx_q)
         3'd0:     hdr_byte = SYNC0;
         3'd1:     hdr_byte = SYNC1;
         OFS_ADDR: hdr_byte = addr_q;
         OFS_NH:   hdr_byte = 8'h00;
         OFS_NL:   hdr_byte = {1'b0, len_q};
         OFS_HCRC: hdr_byte = crc_cur;
         default:  hdr_byte = SYNC0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      addr_d    = addr_q;
      hdr_idx_d = hdr_idx_q;
      rd_ptr_d  = rd_ptr_q;
      q_d       = q_q;
      q_acc_d   = 1'b0;
      done_d    = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = (state_q == ST_IDLE) ? 7'd0 : len_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.d_accepted) begin
               ram_we  = 1'b1;
               addr_d  = bus.addr;
               len_d   = 7'd1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (bus.d_accepted) begin
               if (len_q < 7'(MAX_LEN)) begin
                  ram_we = 1'b1;
                  len_d  = len_q + 7'd1;
               end
            end else begin
               hdr_idx_d = 3'd0;
               rd_ptr_d  = 7'd0;
               state_d   = ST_HDR;
            end
         end
         ST_HDR: begin
            if (bus.tx_ready) begin
               q_acc_d = 1'b1;
               q_d     = hdr_byte;
               if (hdr_idx_q == 3'(HDR_LEN - 1)) state_d = ST_DATA;
               else                               hdr_idx_d = hdr_idx_q + 3'd1;
            end
         end
         ST_DATA: begin
            if (bus.tx_ready) begin
               q_acc_d  = 1'b1;
               q_d      = ram_rdata;
               rd_ptr_d = rd_ptr_q + 7'd1;
               if (rd_ptr_q == len_q - 7'd1) state_d = ST_CRC;
            end
         end
         ST_CRC: begin
            if (bus.tx_ready) begin
               q_acc_d = 1'b1;
               q_d     = crc_cur;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE) || done_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= ST_IDLE;
         len_q     <= 7'd0;
         addr_q    <= 8'h00;
         hdr_idx_q <= 3'd0;
         rd_ptr_q  <= 7'd0;
         q_q       <= 8'h00;
         q_acc_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         addr_q    <= addr_d;
         hdr_idx_q <= hdr_idx_d;
         rd_ptr_q  <= rd_ptr_d;
         q_q       <= q_d;
         q_acc_q   <= q_acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.q          = q_q;
   assign bus.q_accepted = q_acc_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
endmodule

// File: tb/tb_usb_encoder.sv
// Directed bench for usb_encoder: frame content, flow control, overflow,
// ignored strobes and mid-frame reset.
module tb_usb_encoder;
   logic clk = 1'b0;
   logic n_rst;
   usb_encoder_if bus();

   usb_encoder dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] pay [0:129];
   int  done_cnt = 0;
   int  done_pos = -1;
   int  rdy_viol = 0;
   int  cyc = 0;
   int  first_cyc = 0;
   int  last_cyc = 0;
   bit  rand_rdy = 1'b0;
   logic rdy_last;

   always @(negedge clk) bus.tx_ready = rand_rdy ? ($urandom_range(0, 9) >= 4) : 1'b1;

   always @(posedge clk) begin
      rdy_last = bus.tx_ready;
      cyc++;
      #1;
      if (bus.q_accepted === 1'b1) begin
         if (rdy_last !== 1'b1) rdy_viol++;
         rx_q.push_back(bus.q);
         if (rx_q.size() == 1) first_cyc = cyc;
         last_cyc = cyc;
      end
      if (bus.frame_done === 1'b1) begin
         done_cnt++;
         done_pos = rx_q.size() - 1;
      end
   end

   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   task automatic clear_mon();
      rx_q.delete();
      done_cnt = 0;
      done_pos = -1;
      rdy_viol = 0;
   endtask

   task automatic build_exp(input logic [7:0] a, input int n);
      int m;
      logic [7:0] c;
      m = (n > 120) ? 120 : n;
      exp_q.delete();
      exp_q.push_back(8'h5E);
      exp_q.push_back(8'h4D);
      exp_q.push_back(a);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(m));
      c = 8'h00;
      for (int i = 0; i < 5; i++) c = crc_step(c, exp_q[i]);
      exp_q.push_back(c);
      for (int i = 0; i < m; i++) exp_q.push_back(pay[i]);
      c = 8'h00;
      for (int i = 0; i < exp_q.size(); i++) c = crc_step(c, exp_q[i]);
      exp_q.push_back(c);
   endtask

   task automatic send_burst(input logic [7:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.d_accepted = 1'b1;
         bus.d          = pay[i];
         bus.addr       = (i == 0) ? a : 8'hEE;
      end
      @(negedge clk);
      bus.d_accepted = 1'b0;
   endtask

   task automatic wait_done(output bit to);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      to = (done_cnt == 0);
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      bus.d_accepted = 1'b0;
      bus.d = 8'h00;
      bus.addr = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", bus.q); end
      checks++; if (bus.q_accepted !== 1'b0) begin errors++; $display("FAIL reset_q_accepted got %b exp 0", bus.q_accepted); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", bus.frame_done); end
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic(input bit toggle, input string tag);
      logic [7:0] exp1 [0:12];
      bit to;
      exp1 = '{8'h5E, 8'h4D, 8'h01, 8'h00, 8'h06, 8'hB4,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h2F};
      rand_rdy = toggle;
      for (int i = 0; i < 6; i++) pay[i] = 8'(i + 1);
      clear_mon();
      send_burst(8'h01, 6);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy_during got %b exp 1", tag, bus.busy); end
      wait_done(to);
      checks++; if (to) begin errors++; $display("FAIL %s timeout got no frame_done exp frame_done", tag); end
      checks++; if (rx_q.size() != 13) begin errors++; $display("FAIL %s length got %0d exp 13", tag, rx_q.size()); end
      for (int i = 0; i < 13 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp1[i]) begin errors++; $display("FAIL %s byte%0d got %h exp %h", tag, i, rx_q[i], exp1[i]); end
      end
      checks++; if (done_pos != 12) begin errors++; $display("FAIL %s done_pos got %0d exp 12", tag, done_pos); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_cnt got %0d exp 1", tag, done_cnt); end
      if (!toggle) begin
         checks++; if (last_cyc - first_cyc != 12) begin errors++; $display("FAIL %s span got %0d exp 12", tag, last_cyc - first_cyc); end
      end else begin
         checks++; if (rdy_viol != 0) begin errors++; $display("FAIL %s rdy_violations got %0d exp 0", tag, rdy_viol); end
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b exp 0", tag, bus.busy); end
      rand_rdy = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_loopback();
      int lens [4];
      bit to;
      int bad;
      logic [7:0] c;
      logic [7:0] a;
      lens = '{1, 2, 57, 120};
      rand_rdy = 1'b1;
      foreach (lens[j]) begin
         for (int i = 0; i < lens[j]; i++) pay[i] = 8'($urandom_range(0, 255));
         a = 8'($urandom_range(0, 255));
         clear_mon();
         send_burst(a, lens[j]);
         wait_done(to);
         checks++; if (to) begin errors++; $display("FAIL loop%0d timeout got no frame_done exp frame_done", lens[j]); end
         checks++; if (rx_q.size() != lens[j] + 7) begin errors++; $display("FAIL loop%0d length got %0d exp %0d", lens[j], rx_q.size(), lens[j] + 7); end
         if (rx_q.size() == lens[j] + 7) begin
            checks++;
            if (rx_q[0] !== 8'h5E || rx_q[1] !== 8'h4D || rx_q[2] !== a) begin
               errors++; $display("FAIL loop%0d sync_addr got %h %h %h exp 5e 4d %h", lens[j], rx_q[0], rx_q[1], rx_q[2], a);
            end
            checks++;
            if ({rx_q[3], rx_q[4]} !== 16'(lens[j])) begin
               errors++; $display("FAIL loop%0d n got %h%h exp %04h", lens[j], rx_q[3], rx_q[4], 16'(lens[j]));
            end
            c = 8'h00;
            for (int i = 0; i < 6; i++) c = crc_step(c, rx_q[i]);
            checks++; if (c !== 8'h00) begin errors++; $display("FAIL loop%0d hcrc_residual got %h exp 00", lens[j], c); end
            c = 8'h00;
            for (int i = 0; i < rx_q.size(); i++) c = crc_step(c, rx_q[i]);
            checks++; if (c !== 8'h00) begin errors++; $display("FAIL loop%0d fcrc_residual got %h exp 00", lens[j], c); end
            bad = 0;
            for (int i = 0; i < lens[j]; i++) if (rx_q[6 + i] !== pay[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL loop%0d payload got %0d bad bytes exp 0", lens[j], bad); end
         end
         checks++; if (rdy_viol != 0) begin errors++; $display("FAIL loop%0d rdy_violations got %0d exp 0", lens[j], rdy_viol); end
      end
      rand_rdy = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_overflow();
      bit to;
      int bad;
      for (int i = 0; i < 130; i++) pay[i] = 8'(i * 7 + 3);
      clear_mon();
      send_burst(8'h55, 130);
      wait_done(to);
      build_exp(8'h55, 130);
      checks++; if (to) begin errors++; $display("FAIL ovf timeout got no frame_done exp frame_done"); end
      checks++; if (rx_q.size() != 127) begin errors++; $display("FAIL ovf strobes got %0d exp 127", rx_q.size()); end
      if (rx_q.size() == 127) begin
         checks++;
         if (rx_q[3] !== 8'h00 || rx_q[4] !== 8'h78) begin errors++; $display("FAIL ovf n got %h%h exp 0078", rx_q[3], rx_q[4]); end
         bad = 0;
         for (int i = 0; i < 127; i++) if (rx_q[i] !== exp_q[i]) bad++;
         checks++; if (bad != 0) begin errors++; $display("FAIL ovf frame got %0d bad bytes exp 0", bad); end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ignored();
      bit to;
      int n;
      int drop;
      int bad;
      for (int i = 0; i < 5; i++) pay[i] = 8'hA0 + 8'(i);
      clear_mon();
      send_burst(8'h33, 5);
      n = 0;
      drop = 0;
      while (done_cnt == 0 && n < 2000) begin
         @(negedge clk);
         n++;
         if (done_cnt == 0) begin
            bus.d_accepted = n[0];
            bus.d = 8'hC3;
            if (bus.busy !== 1'b1) drop++;
         end else begin
            bus.d_accepted = 1'b0;
         end
      end
      bus.d_accepted = 1'b0;
      @(negedge clk);
      build_exp(8'h33, 5);
      checks++; if (done_cnt == 0) begin errors++; $display("FAIL ign timeout got no frame_done exp frame_done"); end
      checks++; if (drop != 0) begin errors++; $display("FAIL ign busy_drops got %0d exp 0", drop); end
      bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL ign frame got %0d bad (len %0d) exp 0 (len %0d)", bad, rx_q.size(), exp_q.size()); end
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign idle_after got busy %b exp 0", bus.busy); end
      for (int i = 0; i < 9; i++) pay[i] = 8'h10 * 8'(i) + 8'h0F;
      clear_mon();
      send_burst(8'h7A, 9);
      wait_done(to);
      build_exp(8'h7A, 9);
      bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
      checks++; if (to || bad != 0) begin errors++; $display("FAIL ign next_frame got %0d bad (timeout %0b) exp 0", bad, to); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      for (int i = 0; i < 20; i++) pay[i] = 8'h40 + 8'(i);
      clear_mon();
      send_burst(8'h99, 20);
      n = 0;
      while (rx_q.size() < 9 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++; if (rx_q.size() < 9) begin errors++; $display("FAIL rstmid reach_data got %0d bytes exp 9", rx_q.size()); end
      n_rst = 1'b0;
      #1;
      checks++; if (bus.q_accepted !== 1'b0) begin errors++; $display("FAIL rstmid q_accepted got %b exp 0", bus.q_accepted); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid busy got %b exp 0", bus.busy); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rstmid frame_done got %b exp 0", bus.frame_done); end
      repeat (2) @(negedge clk);
      clear_mon();
      n_rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (rx_q.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL rstmid stray_strobes got %0d exp 0", rx_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic(1'b0, "basic");
      test_basic(1'b1, "toggle");
      test_loopback();
      test_overflow();
      test_ignored();
      test_reset_mid();
      test_basic(1'b0, "after_reset");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
